// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave codes, command layout and the scheduler state encoding.
package spi_pkg;

  localparam int SPI_BYTE_W      = 8;
  localparam int SPI_XFER_CYCLES = 9;
  localparam int SPI_SS_W        = 2;
  localparam int SPI_CMD_W       = SPI_SS_W + SPI_BYTE_W;

  localparam logic [SPI_SS_W-1:0] SS0        = 2'd0;
  localparam logic [SPI_SS_W-1:0] SS1        = 2'd1;
  localparam logic [SPI_SS_W-1:0] SS2        = 2'd2;
  localparam logic [SPI_SS_W-1:0] SS_INVALID = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE,
    REJECT
  } state_t;

  typedef struct packed {
    logic [SPI_SS_W-1:0]   slave;
    logic [SPI_BYTE_W-1:0] data;
  } spi_cmd_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous FIFO with full/empty/occupancy; a full FIFO refuses pushes even while popping.
module spi_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Command-queue front end for the SPI master: launches queued byte transfers one at a time,
// times each exchange and returns the captured byte on a single-entry response register.
module spi_txn_scheduler
  import spi_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int XFER_CYCLES = SPI_XFER_CYCLES,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SPI_SS_W-1:0]   cmd_slave,
  input  logic [SPI_BYTE_W-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SPI_SS_W-1:0]   rsp_slave,
  output logic [SPI_BYTE_W-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  start,
  output logic [SPI_SS_W-1:0]   slaveSelect,
  output logic [SPI_BYTE_W-1:0] masterDataToSend,
  input  logic [SPI_BYTE_W-1:0] masterDataReceived,
  output logic                  busy
);

  localparam int WCW = $clog2(XFER_CYCLES) + 1;
  localparam int CW  = $clog2(DEPTH + 1);

  state_t         state_q;
  state_t         state_d;
  spi_cmd_t       head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           fifo_pop;
  logic           launch_ok;
  logic [WCW-1:0] wait_cnt;
  logic [3:0]     gap_cnt;

  spi_cmd_fifo #(
    .WIDTH (SPI_CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid && cmd_ready),
    .wr_data ({cmd_slave, cmd_data}),
    .pop     (fifo_pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (fifo_count != '0) || (state_q != IDLE) || rsp_valid;

  // The gate looks at the registered rsp_valid, so a drain in the same cycle does not open it.
  assign launch_ok = !fifo_empty && !rsp_valid && (gap_cnt == '0);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch_ok) begin
          fifo_pop = 1'b1;
          state_d  = (head.slave == SS_INVALID) ? REJECT : LAUNCH;
        end
      end
      LAUNCH: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // Leave when this cycle's decrement reaches zero, so capture lands XFER_CYCLES after start.
        if (wait_cnt <= WCW'(1)) state_d = CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      slaveSelect      <= '0;
      masterDataToSend <= '0;
      wait_cnt         <= '0;
      gap_cnt          <= '0;
      rsp_valid        <= 1'b0;
      rsp_err          <= 1'b0;
      rsp_data         <= '0;
      rsp_slave        <= '0;
    end else begin
      state_q <= state_d;

      // Master inputs only change on a real launch, never mid-transfer or for a rejected slave.
      if (fifo_pop && head.slave != SS_INVALID) begin
        slaveSelect      <= head.slave;
        masterDataToSend <= head.data;
      end

      if (state_q == LAUNCH)                     wait_cnt <= WCW'(XFER_CYCLES - 1);
      else if (state_q == WAIT && wait_cnt != 0) wait_cnt <= wait_cnt - 1'b1;

      // The gap only runs once the response register has emptied.
      if (state_q == CAPTURE)                 gap_cnt <= 4'(GAP_CYCLES);
      else if (gap_cnt != '0 && !rsp_valid)   gap_cnt <= gap_cnt - 1'b1;

      if (state_q == CAPTURE) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_data  <= masterDataReceived;
        rsp_slave <= slaveSelect;
      end else if (state_q == REJECT) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_data  <= '0;
        rsp_slave <= SS_INVALID;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Scoreboard bench for spi_txn_scheduler with a loopback SPI master model and randomized traffic.
module tb_spi_txn_scheduler;
  import spi_pkg::*;

  localparam int DEPTH = 4;
  localparam int XFER  = 9;
  localparam int GAP   = 1;
  // Earliest start-to-start distance: capture, one valid cycle drained at once, gap, IDLE pop.
  localparam int MIN_SPACING = XFER + GAP + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_slave = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [1:0] rsp_slave;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       start;
  logic [1:0] slaveSelect;
  logic [7:0] masterDataToSend;
  logic [7:0] masterDataReceived;
  logic       busy;

  spi_txn_scheduler #(.DEPTH(DEPTH), .XFER_CYCLES(XFER), .GAP_CYCLES(GAP)) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_slave          (cmd_slave),
    .cmd_data           (cmd_data),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_slave          (rsp_slave),
    .rsp_data           (rsp_data),
    .rsp_err            (rsp_err),
    .start              (start),
    .slaveSelect        (slaveSelect),
    .masterDataToSend   (masterDataToSend),
    .masterDataReceived (masterDataReceived),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Loopback SPI master: shifts MOSI (MSB first) straight into MISO, one bit per clock after start.
  logic [7:0] m_tx = '0;
  logic [7:0] m_rx = '0;
  int         m_cnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      m_cnt <= 0;
      m_rx  <= '0;
    end else if (start) begin
      m_tx  <= masterDataToSend;
      m_cnt <= 8;
    end else if (m_cnt > 0) begin
      m_rx  <= {m_rx[6:0], m_tx[7]};
      m_tx  <= {m_tx[6:0], 1'b0};
      m_cnt <= m_cnt - 1;
    end
  end
  assign masterDataReceived = m_rx;

  typedef struct packed {
    logic [1:0] slave;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  rsp_t       exp_rsp[$];
  logic [9:0] exp_start[$];

  // Monitor: launches, transfer hold, response stability and response scoreboard.
  int         last_start = -1000;
  int         start_count = 0;
  logic       in_xfer = 1'b0;
  logic [9:0] xfer_cmd = '0;
  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  rsp_t       p_rsp = '0;
  always @(negedge clk) begin
    if (reset) begin
      in_xfer    = 1'b0;
      last_start = -1000;
      p_valid    = 1'b0;
    end else begin
      if (start) begin
        start_count++;
        check("start_spacing_ok", 32'(cyc - last_start >= MIN_SPACING), 1);
        last_start = cyc;
        if (exp_start.size() == 0) check("start_unexpected", 1, 0);
        else check("start_cmd", {slaveSelect, masterDataToSend}, exp_start.pop_front());
        in_xfer  = 1'b1;
        xfer_cmd = {slaveSelect, masterDataToSend};
      end else if (in_xfer) begin
        if (rsp_valid) in_xfer = 1'b0;
        else check("master_inputs_held", {slaveSelect, masterDataToSend}, xfer_cmd);
      end
      if (p_valid && !p_ready)
        check("rsp_stable", {rsp_valid, rsp_slave, rsp_data, rsp_err}, {1'b1, p_rsp});
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp_match", {rsp_slave, rsp_data, rsp_err}, exp_rsp.pop_front());
      end
      p_valid = rsp_valid;
      p_ready = rsp_ready;
      p_rsp   = {rsp_slave, rsp_data, rsp_err};
    end
  end

  logic rnd_mode = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_mode) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // All main-thread tasks start and end just after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [1:0] s, input logic [7:0] d, output int acc);
    acc       = -1;
    cmd_valid = 1'b1;
    cmd_slave = s;
    cmd_data  = d;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc;
        if (s == SS_INVALID) exp_rsp.push_back('{slave: SS_INVALID, data: 8'h00, err: 1'b1});
        else begin
          exp_rsp.push_back('{slave: s, data: d, err: 1'b0});
          exp_start.push_back({s, d});
        end
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) check("cmd_accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int sc);
    sc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start) begin
        sc = cyc;
        break;
      end
    end
    if (sc < 0) check("start_timeout", 1, 0);
    step(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_rsp.size() == 0 && !busy) break;
      step(1);
    end
    check("drain_queue_empty", exp_rsp.size(), 0);
    check("drain_not_busy", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, start, 0);
    check({tag, "_slaveSelect"}, slaveSelect, 0);
    check({tag, "_masterDataToSend"}, masterDataToSend, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_slave"}, rsp_slave, 0);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int acc;
    int a[5];
    int sc;
    int first_start;
    int first_rsp;
    int nstart;
    int bad;
    int x;

    step(2);
    @(negedge clk);
    check_reset_outputs("reset");
    step(1);
    reset = 1'b0;
    step(1);

    // Single transfer: latency and loopback data.
    send_cmd(2'd1, 8'hA5, acc);
    first_start = -1;
    first_rsp   = -1;
    nstart      = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (start) begin
        nstart++;
        if (first_start < 0) first_start = cyc;
      end
      if (rsp_valid && first_rsp < 0) first_rsp = cyc;
    end
    step(1);
    check("t1_start_latency", 32'(first_start - acc), 2);
    check("t1_start_count", nstart, 1);
    check("t1_rsp_latency", 32'(first_rsp - acc), 12);
    drain();

    // Fill the FIFO while a transfer is in flight; the fifth waits for the next pop.
    send_cmd(2'd0, 8'h3C, acc);
    wait_start(sc);
    for (int k = 0; k < 4; k++) send_cmd(2'($urandom_range(0, 2)), 8'($urandom), a[k]);
    for (int k = 1; k < 4; k++) check("t2_back_to_back", 32'(a[k] - a[0]), 32'(k));
    @(negedge clk);
    check("t2_cmd_ready_low_when_full", cmd_ready, 0);
    step(1);
    send_cmd(2'd2, 8'h81, a[4]);
    check("t2_fifth_accept_at_next_start", 32'(a[4]), 32'(last_start));
    drain();

    // Invalid slave between two valid commands.
    nstart = start_count;
    send_cmd(2'd0, 8'h11, acc);
    send_cmd(2'd3, 8'hEE, acc);
    send_cmd(2'd2, 8'h7E, acc);
    drain();
    check("t3_start_count", 32'(start_count - nstart), 2);

    // Response back-pressure with a second command queued.
    rsp_ready = 1'b0;
    send_cmd(2'd1, 8'hC3, acc);
    send_cmd(2'd2, 8'h5A, acc);
    first_rsp = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        first_rsp = cyc;
        break;
      end
    end
    check("t4_rsp_arrived", 32'(first_rsp >= 0), 1);
    step(1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start || !rsp_valid) bad++;
    end
    check("t4_hold_no_start_valid_kept", bad, 0);
    step(1);
    rsp_ready = 1'b1;
    x = cyc;
    wait_start(sc);
    check("t4_restart_delay", 32'(sc - x), GAP + 2);
    drain();

    // Reset in the middle of a transfer with more commands queued.
    send_cmd(2'd0, 8'h96, acc);
    send_cmd(2'd1, 8'h69, acc);
    send_cmd(2'd2, 8'hF0, acc);
    wait_start(sc);
    step(3);
    reset = 1'b1;
    exp_rsp.delete();
    exp_start.delete();
    step(1);
    @(negedge clk);
    check_reset_outputs("t5_after_reset");
    step(1);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid || start || busy) bad++;
    end
    check("t5_no_activity_after_reset", bad, 0);
    step(1);

    // Randomized traffic with random back-pressure.
    rnd_mode = 1'b1;
    for (int n = 0; n < 24; n++) begin
      send_cmd(2'($urandom_range(0, 3)), 8'($urandom), acc);
      step($urandom_range(0, 6));
    end
    rnd_mode  = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("rnd_starts_consumed", exp_start.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
